mem_access_unit: RTL and testbench

- Parametrised MAR/MDR memory-access unit for the datapath; replaces the fixed single-cycle MAR/MDR/RAM wiring.
- Holds MAR and MDR, issues read/write transactions to a memory with variable latency over a level req/ack handshake, and reports busy/done so the control unit can stall.
- Sits between BusMuxOut, the bus-mux MDR input and the RAM instance.

---
 rtl/mau_pkg.sv | 20 ++
 rtl/mau_watchdog.sv | 42 ++++
 rtl/mem_access_unit.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared types and default sizes for the MAR/MDR memory-access unit,
// so the datapath top and the bench agree on widths and state encoding.
package mau_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mau_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mau_op_e;

  localparam int MAU_DATA_W  = 32;
  localparam int MAU_ADDR_W  = 9;
  localparam int MAU_TIMEOUT = 16;

endpackage

// File: rtl/mau_watchdog.sv
// Cycle counter that flags the last allowed ACCESS cycle; only present when
// MAU_TIMEOUT_EN is defined (the default build carries no watchdog at all).
`ifdef MAU_TIMEOUT_EN
module mau_watchdog #(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of completed enabled cycles since the last clear
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CW'(MAX - 1));

endmodule
`endif

// File: rtl/mem_access_unit.sv
// MAR/MDR memory-access unit: holds address/data and runs one req/ack memory
// transaction at a time. Define MAU_TIMEOUT_EN to add the ACCESS watchdog.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_W  = MAU_DATA_W,
  parameter int ADDR_W  = MAU_ADDR_W,
  parameter int TIMEOUT = MAU_TIMEOUT
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_ld,
  input  logic              mdr_ld,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic [DATA_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] mar_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  mau_state_e        state_q, state_d;
  mau_op_e           op_q, op_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              timeout_s;

  // next state; MAR/MDR loads only in IDLE so the memory sees stable operands
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mar_d    = mar_q;
    mdr_d    = mdr_q;
    done_d   = 1'b0;
    mem_rd_d = 1'b0;
    mem_wr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (mar_ld) begin
          mar_d = bus_in[ADDR_W-1:0];
        end else begin
          mar_d = mar_q;
        end
        if (mdr_ld) begin
          mdr_d = bus_in;
        end else begin
          mdr_d = mdr_q;
        end
        // a read takes priority; a simultaneous write is dropped
        if (rd_req) begin
          state_d  = ACCESS;
          op_d     = OP_RD;
          mem_rd_d = 1'b1;
        end else if (wr_req) begin
          state_d  = ACCESS;
          op_d     = OP_WR;
          mem_wr_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (op_q == OP_RD) begin
            mdr_d = mem_rdata;
          end else begin
            mdr_d = mdr_q;
          end
        end else if (timeout_s) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          mem_rd_d = (op_q == OP_RD);
          mem_wr_d = (op_q == OP_WR);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      op_q     <= OP_RD;
      mar_q    <= '0;
      mdr_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mar_q    <= mar_d;
      mdr_q    <= mdr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
    end
  end

`ifdef MAU_TIMEOUT_EN
  logic wd_clear_s;
  logic wd_expired_s;
  logic err_q, err_d;

  assign wd_clear_s = (state_q != ACCESS);

  mau_watchdog #(
    .MAX(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .clr    (clr),
    .clear  (wd_clear_s),
    .en     (!wd_clear_s),
    .expired(wd_expired_s)
  );

  assign timeout_s = wd_expired_s;

  // err is sticky from an abort until the next accepted request
  always_comb begin
    err_d = err_q;
    if ((state_q == IDLE) && (rd_req || wr_req)) begin
      err_d = 1'b0;
    end else if ((state_q == ACCESS) && !mem_ack && timeout_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // error flag register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout_s;

  assign unused_timeout_s = (TIMEOUT > 1);
  assign timeout_s        = 1'b0;
  assign err              = 1'b0;
`endif

  assign mdr_out   = mdr_q;
  assign mar_out   = mar_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: random transactions against a
// word-array memory model; define MAU_TIMEOUT_EN to exercise the watchdog.
module tb_mem_access_unit;
  import mau_pkg::*;

  localparam int DW    = MAU_DATA_W;
  localparam int AW    = MAU_ADDR_W;
  localparam int DEPTH = 1 << AW;
`ifdef MAU_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = MAU_TIMEOUT;
`endif

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic [DW-1:0] bus_in;
  logic          mar_ld, mdr_ld, rd_req, wr_req;
  logic [DW-1:0] mdr_out;
  logic [AW-1:0] mar_out;
  logic          busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  mem_access_unit #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .bus_in   (bus_in),
    .mar_ld   (mar_ld),
    .mdr_ld   (mdr_ld),
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .mdr_out  (mdr_out),
    .mar_out  (mar_out),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] mdr_before;
    logic [DW-1:0] mdr_after;
    bit            err;
    int            cycles;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] dut_mem[DEPTH];
  logic [DW-1:0] ref_mem[DEPTH];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            ack_delay = 0;
  logic [AW-1:0] mar_m;
  logic [DW-1:0] mdr_m;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // Memory side: acks after ack_delay waiting cycles; random ack noise when idle
  int wait_cnt = 0;
  always @(negedge clk) begin
    if (!clr) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_rd || mem_wr) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_rd ? dut_mem[mem_addr] : DW'($urandom);
        if (mem_wr) dut_mem[mem_addr] = mem_wdata;
        wait_cnt  = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = DW'($urandom);
        wait_cnt++;
      end
    end else begin
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = DW'($urandom);
      wait_cnt  = 0;
    end
  end

  // Monitor: checks every access cycle and pops the scoreboard on done
  bit in_acc = 1'b0;
  int acc_cycles = 0;
  always @(posedge clk) begin
    #1;
    if (!clr) begin
      in_acc     = 1'b0;
      acc_cycles = 0;
    end else begin
      if (mem_rd || mem_wr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_access", {mem_rd, mem_wr}, 64'd0);
        end else begin
          if (!in_acc) begin
            chk("op_rd", mem_rd, exp_q[0].rd);
            chk("op_wr", mem_wr, !exp_q[0].rd);
            in_acc     = 1'b1;
            acc_cycles = 0;
          end
          acc_cycles++;
          chk("mem_addr", mem_addr, exp_q[0].addr);
          chk("mar_hold", mar_out, exp_q[0].addr);
          chk("mdr_hold", mdr_out, exp_q[0].mdr_before);
          chk("mem_wdata", mem_wdata, exp_q[0].mdr_before);
          chk("busy_acc", busy, 64'd1);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", done, 64'd0);
        end else begin
          chk("done_cycles", acc_cycles, exp_q[0].cycles);
          chk("mdr_after", mdr_out, exp_q[0].mdr_after);
          chk("err_at_done", err, exp_q[0].err);
          chk("req_low_at_done", {mem_rd, mem_wr}, 64'd0);
          void'(exp_q.pop_front());
        end
        in_acc     = 1'b0;
        acc_cycles = 0;
      end
    end
  end

  task automatic idle_inputs();
    bus_in = DW'($urandom);
    mar_ld = 1'b0;
    mdr_ld = 1'b0;
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_mar"}, mar_out, 64'd0);
    chk({tag, "_mdr"}, mdr_out, 64'd0);
    chk({tag, "_busy"}, busy, 64'd0);
    chk({tag, "_done"}, done, 64'd0);
    chk({tag, "_err"}, err, 64'd0);
    chk({tag, "_memrd"}, mem_rd, 64'd0);
    chk({tag, "_memwr"}, mem_wr, 64'd0);
    chk({tag, "_addr"}, mem_addr, 64'd0);
    chk({tag, "_wdata"}, mem_wdata, 64'd0);
  endtask

  // One IDLE cycle of loads and/or request; records what the transaction must do
  task automatic issue(input logic [DW-1:0] bus, input bit ld_mar, input bit ld_mdr,
                       input bit rd, input bit wr, input int delay, input bit abort);
    exp_t e;
    @(negedge clk);
    bus_in    = bus;
    mar_ld    = ld_mar;
    mdr_ld    = ld_mdr;
    rd_req    = rd;
    wr_req    = wr;
    ack_delay = delay;
    if (ld_mar) mar_m = bus[AW-1:0];
    if (ld_mdr) mdr_m = bus;
    if (rd || wr) begin
      e.rd         = rd;
      e.addr       = mar_m;
      e.mdr_before = mdr_m;
      e.err        = 1'b0;
      e.cycles     = delay + 1;
      if (abort) begin
        e.mdr_after = mdr_m;
        e.err       = 1'b1;
        e.cycles    = TO;
      end else if (rd) begin
        e.mdr_after = ref_mem[mar_m];
      end else begin
        e.mdr_after    = mdr_m;
        ref_mem[mar_m] = mdr_m;
      end
      mdr_m = e.mdr_after;
      exp_q.push_back(e);
    end
  endtask

  // Waits for the unit to return to IDLE; mode 1 = random junk, 2 = fixed junk
  task automatic finish_txn(input int mode, input int limit);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      idle_inputs();
      if (!busy) break;
      if (n >= limit) begin
        chk("txn_timeout", busy, 64'd0);
        break;
      end
      n++;
      if (mode == 1) begin
        mar_ld = 1'($urandom_range(0, 1));
        mdr_ld = 1'($urandom_range(0, 1));
        rd_req = 1'($urandom_range(0, 1));
        wr_req = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
        case (n)
          2: begin bus_in = 32'hAAAA_AAAA; mdr_ld = 1'b1; end
          3: begin bus_in = 32'h0000_0010; mar_ld = 1'b1; end
          4: begin wr_req = 1'b1; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic apply_reset(input string tag);
    clr = 1'b0;
    #1;
    check_reset(tag);
    exp_q.delete();
    mar_m = '0;
    mdr_m = '0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global time limit reached");
  end

  initial begin
    int            kind;
    bit            rd, wr;
    logic [DW-1:0] b;
    idle_inputs();
    mem_rdata = '0;
    mem_ack   = 1'b0;
    mar_m     = '0;
    mdr_m     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      b          = DW'($urandom);
      dut_mem[i] = b;
      ref_mem[i] = b;
    end
    #2 clr = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("rst0");
    clr = 1'b1;

    // reset in the middle of a read that never completes
    issue(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1000000, 1'b0);
    @(negedge clk);
    idle_inputs();
`ifndef MAU_TIMEOUT_EN
    repeat (100) @(negedge clk);
`else
    @(negedge clk);
`endif
    chk("busy_wait", busy, 64'd1);
    chk("memrd_wait", mem_rd, 64'd1);
    apply_reset("rst_mid");

    // write 0xDEADBEEF to 0x0A5, ack in third ACCESS cycle
    issue(32'h0000_00A5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    issue(32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    issue(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    finish_txn(0, 50);
    chk("wr_mdr_kept", mdr_out, 64'hDEAD_BEEF);

    // zero-wait read at top address
    dut_mem[511] = 32'h1234_5678;
    ref_mem[511] = 32'h1234_5678;
    issue(32'h0000_01FF, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    issue(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    finish_txn(0, 50);
    chk("rd0_mdr", mdr_out, 64'h1234_5678);

    // address truncation
    issue(32'hFFFF_FE03, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("mar_trunc", mar_out, 64'h003);

    // loads and write request while busy must be ignored
    issue(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5, 1'b0);
    finish_txn(2, 50);
    chk("blk_mar", mar_out, 64'h003);
    chk("blk_mdr", mdr_out, mdr_m);
    repeat (3) @(negedge clk);
    chk("blk_idle", busy, 64'd0);

    // simultaneous read and write request: read only
    issue(32'h0000_0077, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    finish_txn(1, 50);
    chk("both_mdr", mdr_out, ref_mem[9'h077]);

`ifdef MAU_TIMEOUT_EN
    // no ack: abort after TO cycles with sticky err
    issue(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1000000, 1'b1);
    finish_txn(0, 50);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 64'd1);
    chk("to_mdr_kept", mdr_out, mdr_m);
    issue(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    @(negedge clk);
    idle_inputs();
    chk("err_cleared", err, 64'd0);
    finish_txn(0, 50);
`endif

    // randomized traffic over a small address window so reads see earlier writes
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 3);
      rd   = (kind != 1);
      wr   = (kind == 1) || (kind == 2);
      if ($urandom_range(0, 1) == 1) begin
        b = DW'($urandom) & 32'hFFFF_FE07;
        issue(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 1'b0);
      end
      b = DW'($urandom) & 32'hFFFF_FE07;
      issue(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd, wr,
            $urandom_range(0, 6), 1'b0);
      finish_txn(1, 60);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
